// File: rtl/address_generator_pkg.sv
// ============================================================================
// address_generator_pkg : shared BIST direction encoding and terminal-address helper
// Revision 1.0
// ============================================================================
`default_nettype none

package address_generator_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Address at which a sweep in direction d ends and the next step wraps.
  function automatic int terminal_addr(input int size, input logic d);
    return (d == DIR_DOWN) ? 0 : size - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/address_generator.sv
// ============================================================================
// address_generator : up/down BIST address counter with wrap pulse and terminal flag
// Optional sweep counter output pass_cnt enabled by macro ADDR_GEN_PASS_CNT_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module address_generator
  import address_generator_pkg::*;
#(
  parameter  int ARRAY_SIZE = 16,
  localparam int ADDR_WIDTH = $clog2(ARRAY_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  last,
`ifdef ADDR_GEN_PASS_CNT_EN
  output logic [7:0]            pass_cnt,
`endif
  output logic                  wrap
);

  localparam logic [ADDR_WIDTH-1:0] c_TOP = ADDR_WIDTH'(ARRAY_SIZE - 1);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wrap;
  logic [ADDR_WIDTH-1:0] w_term;
  logic                  w_at_end;
  logic [ADDR_WIDTH-1:0] w_next;
  logic                  w_wrap;

  // Explicit terminal compare keeps non-power-of-two sizes inside 0..ARRAY_SIZE-1.
  always_comb begin
    w_term   = ADDR_WIDTH'(terminal_addr(ARRAY_SIZE, dir));
    w_at_end = (r_addr == w_term);
    w_next   = r_addr;
    w_wrap   = 1'b0;
    if (en) begin
      if (w_at_end) begin
        w_next = (dir == DIR_UP) ? '0 : c_TOP;
        w_wrap = 1'b1;
      end else if (dir == DIR_UP) begin
        w_next = r_addr + 1'b1;
      end else begin
        w_next = r_addr - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_addr <= w_next;
      r_wrap <= w_wrap;
    end
  end

`ifdef ADDR_GEN_PASS_CNT_EN
  logic [7:0] r_pass_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pass_cnt <= 8'd0;
    end else if (w_wrap) begin
      r_pass_cnt <= r_pass_cnt + 8'd1;
    end
  end

  assign pass_cnt = r_pass_cnt;
`endif

  assign addr_out = r_addr;
  assign wrap     = r_wrap;
  assign last     = w_at_end;

endmodule

`default_nettype wire

// File: tb/tb_address_generator.sv
// ============================================================================
// tb_address_generator : directed + random check of two address_generator sizes (16, 10)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_address_generator;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic       rst;
  logic       en;
  logic       dir;
  logic [3:0] addr_a, addr_b;
  logic       last_a, last_b;
  logic       wrap_a, wrap_b;
`ifdef ADDR_GEN_PASS_CNT_EN
  logic [7:0] pc_a, pc_b;
`endif

  address_generator #(.ARRAY_SIZE(16)) dut_a (
    .clk      (tb_clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .addr_out (addr_a),
    .last     (last_a),
`ifdef ADDR_GEN_PASS_CNT_EN
    .pass_cnt (pc_a),
`endif
    .wrap     (wrap_a)
  );

  address_generator #(.ARRAY_SIZE(10)) dut_b (
    .clk      (tb_clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .addr_out (addr_b),
    .last     (last_b),
`ifdef ADDR_GEN_PASS_CNT_EN
    .pass_cnt (pc_b),
`endif
    .wrap     (wrap_b)
  );

  int errors = 0;
  int checks = 0;
  int size_m   [2] = '{16, 10};
  int exp_addr [2] = '{0, 0};
  int exp_wrap [2] = '{0, 0};
  int exp_pc   [2] = '{0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_inst(input int k, input logic [3:0] a, input logic w,
                            input logic l, input logic [7:0] pc);
    int exp_last;
    exp_last = ((dir == 1'b0) && (exp_addr[k] == size_m[k] - 1)) ||
               ((dir == 1'b1) && (exp_addr[k] == 0)) ? 1 : 0;
    check($sformatf("addr%0d", k), 32'(a), 32'(exp_addr[k]));
    check($sformatf("wrap%0d", k), 32'(w), 32'(exp_wrap[k]));
    check($sformatf("last%0d", k), 32'(l), 32'(exp_last));
    check($sformatf("range%0d", k), 32'(int'(a) < size_m[k]), 32'd1);
`ifdef ADDR_GEN_PASS_CNT_EN
    check($sformatf("pass_cnt%0d", k), 32'(pc), 32'(exp_pc[k]));
`else
    if (pc != 8'd0) $display("unexpected pass count input %0d", pc);
`endif
  endtask

  task automatic check_all();
`ifdef ADDR_GEN_PASS_CNT_EN
    check_inst(0, addr_a, wrap_a, last_a, pc_a);
    check_inst(1, addr_b, wrap_b, last_b, pc_b);
`else
    check_inst(0, addr_a, wrap_a, last_a, 8'd0);
    check_inst(1, addr_b, wrap_b, last_b, 8'd0);
`endif
  endtask

  // Reference: modular stepping through 0..N-1, wrap flagged when crossing the end.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        exp_addr[k] = 0;
        exp_wrap[k] = 0;
        exp_pc[k]   = 0;
      end else if (en) begin
        if (dir == 1'b0) begin
          exp_wrap[k] = (exp_addr[k] == size_m[k] - 1) ? 1 : 0;
          exp_addr[k] = (exp_addr[k] + 1) % size_m[k];
        end else begin
          exp_wrap[k] = (exp_addr[k] == 0) ? 1 : 0;
          exp_addr[k] = (exp_addr[k] + size_m[k] - 1) % size_m[k];
        end
        if (exp_wrap[k] == 1) exp_pc[k] = (exp_pc[k] + 1) % 256;
      end else begin
        exp_wrap[k] = 0;
      end
    end
  endtask

  task automatic cycle(input logic e, input logic d);
    en  = e;
    dir = d;
    @(posedge tb_clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Called just after an edge: pulse reset between edges, release before the next one.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_addr[k] = 0;
      exp_wrap[k] = 0;
      exp_pc[k]   = 0;
    end
    check_all();
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    dir = 1'b0;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    #2;
    rst = 1'b1;
    cycle(1'b0, 1'b0);

    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 1'b0);
      check("asc_seq", 32'(addr_a), 32'((i + 1) % 16));
      check("asc_wrap", 32'(wrap_a), 32'(i == 15));
    end

    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("hold", 32'(addr_a), 32'd1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("resume", 32'(addr_a), 32'd3);

    async_reset();
    check("after_async", 32'(addr_a), 32'd0);
    cycle(1'b1, 1'b0);
    check("post_reset_step", 32'(addr_a), 32'd1);

    async_reset();
    dir = 1'b1;
    #1;
    check("last_desc_at0", 32'(last_a), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1);
      check("desc_seq", 32'(addr_a), 32'(15 - i));
      check("desc_wrap", 32'(wrap_a), 32'(i == 0));
    end

    async_reset();
    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, 1'b0);
      check("np2_seq", 32'(addr_b), 32'((i + 1) % 10));
    end

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) async_reset();
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
